// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - reset stretcher, run/step/halt controller and cycle/retire counters for the MIPS core
// Optional watchdog: define RUN_CTRL_WDOG_EN to enable the no-retire timeout and the TIMEOUT state.
module cpu_run_ctrl #(
  parameter int RST_CYCLES  = 4,
  parameter int CNT_W       = 32,
  parameter int STEP_W      = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              halt_req,
  input  logic              clr_cnt,
  input  logic              retire,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              done,
  output logic              timeout
);

  localparam logic [2:0] S_RST     = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic              wdog_hit;

`ifdef RUN_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d;

  // Watchdog: count enabled cycles without a retire; the hitting cycle is the last enabled one
  always_comb begin
    wdog_hit = 1'b0;
    wdog_d   = '0;
    if (cpu_en && !retire && !clr_cnt) begin
      wdog_d   = wdog_q + WD_W'(1);
      wdog_hit = (wdog_q == WD_W'(WDOG_CYCLES - 1));
    end
    timeout_d = timeout_q | wdog_hit;
  end

  // Watchdog registers; timeout stays set until rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign wdog_hit        = 1'b0;
  assign timeout         = 1'b0;
`endif

  // State register with reset-stretch counter and step remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      rem_q     <= rem_d;
    end
  end

  // Next-state logic; a watchdog expiry overrides halt and step completion
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    rem_d     = rem_q;
    case (state_q)
      S_RST: begin
        if (rst_cnt_q == RC_LAST) state_d = S_IDLE;
        else rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
      S_IDLE: begin
        if (step_req) begin
          state_d = S_STEP;
          rem_d   = (step_n == '0) ? STEP_W'(1) : step_n;
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        if (wdog_hit) state_d = S_TIMEOUT;
        else if (halt_req || rem_q == STEP_W'(1)) state_d = S_IDLE;
        else rem_d = rem_q - STEP_W'(1);
      end
      S_RUN: begin
        if (wdog_hit) state_d = S_TIMEOUT;
        else if (halt_req) state_d = S_IDLE;
      end
      S_TIMEOUT: state_d = S_TIMEOUT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: enable from registered state, done on any return from RUN/STEP to IDLE
  always_comb begin
    cpu_en      = (state_q == S_RUN) || (state_q == S_STEP);
    done_d      = cpu_en && (state_d == S_IDLE);
    cpu_rst_n_d = (state_d != S_RST);
  end

  // Saturating counters; clear beats increment
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (clr_cnt) begin
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
    end else begin
      if (cpu_en && cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (cpu_en && retire && retire_cnt_q != CNT_MAX) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cpu_rst_n  = cpu_rst_n_q;
  assign state      = state_q;
  assign done       = done_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
  localparam int CNT_W  = 32;
  localparam int STEP_W = 8;
  localparam int WDOG   = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_TO   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, clr_cnt = 1'b0, retire = 1'b0;
  logic [STEP_W-1:0] step_n = '0;
  logic cpu_rst_n, cpu_en, done, timeout;
  logic [2:0] state;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;

  int n_checks = 0;
  int n_fail = 0;

  cpu_run_ctrl #(.RST_CYCLES(4), .CNT_W(CNT_W), .STEP_W(STEP_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .step_n(step_n),
    .halt_req(halt_req), .clr_cnt(clr_cnt), .retire(retire), .cpu_rst_n(cpu_rst_n),
    .cpu_en(cpu_en), .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    run_req = 0; step_req = 0; halt_req = 0; clr_cnt = 0; retire = 0; step_n = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({cpu_rst_n, cpu_en, state, done, timeout} !== 7'd0 || cycle_cnt !== '0 || retire_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got rst=%0b en=%0b st=%0d cyc=%0d ret=%0d expected all 0", cpu_rst_n, cpu_en, state, cycle_cnt, retire_cnt);
      end
    end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (cpu_rst_n !== 1'b0 || state !== 3'd0 || cpu_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stretch edge %0d: got rst=%0b st=%0d expected rst=0 st=0", i, cpu_rst_n, state);
      end
    end
    tick();
    n_checks++;
    if (cpu_rst_n !== 1'b1 || state !== 3'd1 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rst=%0b st=%0d en=%0b expected rst=1 st=1 en=0", cpu_rst_n, state, cpu_en);
    end
  endtask

  task automatic test_step();
    clr_cnt = 1; tick(); clr_cnt = 0;
    step_req = 1; step_n = 8'd3; tick(); step_req = 0; step_n = '0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cpu_en !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL step3_enabled cyc %0d: got en=%0b done=%0b expected en=1 done=0", i, cpu_en, done);
      end
      tick();
    end
    n_checks++;
    if (cpu_en !== 1'b0 || done !== 1'b1 || state !== 3'd1 || cycle_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL step3_end: got en=%0b done=%0b st=%0d cyc=%0d expected 0 1 1 3", cpu_en, done, state, cycle_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL step3_done_width: got done=%0b expected 0", done);
    end
    step_req = 1; step_n = 8'd0; tick(); step_req = 0;
    n_checks++;
    if (cpu_en !== 1'b1) begin
      n_fail++;
      $display("FAIL step0_enabled: got en=%0b expected 1", cpu_en);
    end
    tick();
    n_checks++;
    if (cpu_en !== 1'b0 || done !== 1'b1 || cycle_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL step0_end: got en=%0b done=%0b cyc=%0d expected 0 1 4", cpu_en, done, cycle_cnt);
    end
    tick();
  endtask

  task automatic test_run_halt();
    clr_cnt = 1; tick(); clr_cnt = 0;
    run_req = 1; tick(); run_req = 0;
    retire = 1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (cpu_en !== 1'b1 || state !== 3'd3) begin
        n_fail++;
        $display("FAIL run_enabled cyc %0d: got en=%0b st=%0d expected 1 3", i, cpu_en, state);
      end
      if (i == 9) halt_req = 1;
      tick();
    end
    retire = 0; halt_req = 0;
    n_checks++;
    if (cpu_en !== 1'b0 || done !== 1'b1 || retire_cnt !== 32'd10 || cycle_cnt !== 32'd10 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL run_halt: got en=%0b done=%0b ret=%0d cyc=%0d st=%0d expected 0 1 10 10 1", cpu_en, done, retire_cnt, cycle_cnt, state);
    end
    halt_req = 1; retire = 1; tick(); halt_req = 0; retire = 0;
    n_checks++;
    if (state !== 3'd1 || done !== 1'b0 || retire_cnt !== 32'd10) begin
      n_fail++;
      $display("FAIL idle_ignores: got st=%0d done=%0b ret=%0d expected 1 0 10", state, done, retire_cnt);
    end
  endtask

  task automatic test_priority_clear();
    clr_cnt = 1; tick(); clr_cnt = 0;
    run_req = 1; step_req = 1; step_n = 8'd2; tick(); run_req = 0; step_req = 0; step_n = '0;
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL step_wins: got st=%0d expected 2", state);
    end
    tick(); tick();
    n_checks++;
    if (state !== 3'd1 || done !== 1'b1 || cycle_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL step2_end: got st=%0d done=%0b cyc=%0d expected 1 1 2", state, done, cycle_cnt);
    end
    run_req = 1; tick(); run_req = 0;
    retire = 1; repeat (3) tick();
    n_checks++;
    if (retire_cnt !== 32'd3 || cycle_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL run_count: got ret=%0d cyc=%0d expected 3 5", retire_cnt, cycle_cnt);
    end
    clr_cnt = 1; step_req = 1; step_n = 8'd5; tick(); clr_cnt = 0; step_req = 0; retire = 0;
    n_checks++;
    if (cycle_cnt !== '0 || retire_cnt !== '0 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL clr_beats_inc: got cyc=%0d ret=%0d st=%0d expected 0 0 3", cycle_cnt, retire_cnt, state);
    end
    tick();
    n_checks++;
    if (cycle_cnt !== 32'd1 || retire_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL count_after_clr: got cyc=%0d ret=%0d expected 1 0", cycle_cnt, retire_cnt);
    end
    halt_req = 1; tick(); halt_req = 0; tick();
  endtask

  task automatic test_watchdog();
    clr_cnt = 1; tick(); clr_cnt = 0;
    run_req = 1; tick(); run_req = 0;
`ifdef RUN_CTRL_WDOG_EN
    for (int i = 0; i < WDOG; i++) begin
      n_checks++;
      if (state !== 3'd3 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL wdog_running cyc %0d: got st=%0d to=%0b expected 3 0", i, state, timeout);
      end
      tick();
    end
    n_checks++;
    if (state !== 3'd4 || timeout !== 1'b1 || cpu_en !== 1'b0 || done !== 1'b0 || cycle_cnt !== 32'd16) begin
      n_fail++;
      $display("FAIL wdog_fire: got st=%0d to=%0b en=%0b done=%0b cyc=%0d expected 4 1 0 0 16", state, timeout, cpu_en, done, cycle_cnt);
    end
    run_req = 1; tick(); run_req = 0; tick();
    n_checks++;
    if (state !== 3'd4 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_terminal: got st=%0d to=%0b expected 4 1", state, timeout);
    end
    do_reset();
`else
    repeat (100) tick();
    n_checks++;
    if (state !== 3'd3 || timeout !== 1'b0 || cycle_cnt !== 32'd100) begin
      n_fail++;
      $display("FAIL no_wdog_run: got st=%0d to=%0b cyc=%0d expected 3 0 100", state, timeout, cycle_cnt);
    end
    halt_req = 1; tick(); halt_req = 0; tick();
`endif
  endtask

  task automatic test_async_reset();
    clr_cnt = 1; tick(); clr_cnt = 0;
    run_req = 1; tick(); run_req = 0;
    repeat (7) tick();
    n_checks++;
    if (cycle_cnt !== 32'd7) begin
      n_fail++;
      $display("FAIL pre_async_cnt: got cyc=%0d expected 7", cycle_cnt);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (cpu_en !== 1'b0 || cpu_rst_n !== 1'b0 || cycle_cnt !== '0 || retire_cnt !== '0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL async_clear: got en=%0b rst=%0b cyc=%0d st=%0d expected 0 0 0 0", cpu_en, cpu_rst_n, cycle_cnt, state);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (4) tick();
    n_checks++;
    if (state !== 3'd1 || cpu_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rerun_rst: got st=%0d rst=%0b expected 1 1", state, cpu_rst_n);
    end
  endtask

  // Transaction-level model: mode plus remaining step length, counters as integers
  task automatic test_random();
    int mode, left, wd;
    longint cyc, ret;
    bit exp_done, exp_to, en, hit;
    logic [2:0] exp_state;
    do_reset();
    mode = M_IDLE; left = 0; wd = 0; cyc = 0; ret = 0; exp_done = 0; exp_to = 0;
    for (int i = 0; i < 500; i++) begin
      case (mode)
        M_IDLE:  exp_state = 3'd1;
        M_RUN:   exp_state = 3'd3;
        M_STEP:  exp_state = 3'd2;
        default: exp_state = 3'd4;
      endcase
      n_checks++;
      if (state !== exp_state || cpu_en !== (mode == M_RUN || mode == M_STEP) || done !== exp_done ||
          cycle_cnt !== CNT_W'(cyc) || retire_cnt !== CNT_W'(ret) || timeout !== exp_to) begin
        n_fail++;
        $display("FAIL random cyc %0d: got st=%0d en=%0b done=%0b cyc=%0d ret=%0d to=%0b expected st=%0d done=%0b cyc=%0d ret=%0d to=%0b",
                 i, state, cpu_en, done, cycle_cnt, retire_cnt, timeout, exp_state, exp_done, cyc, ret, exp_to);
      end
      run_req  = ($urandom % 8) == 0;
      step_req = ($urandom % 8) == 0;
      step_n   = STEP_W'($urandom % 6);
      halt_req = ($urandom % 10) == 0;
      clr_cnt  = ($urandom % 25) == 0;
      retire   = ($urandom % 3) != 0;
      en = (mode == M_RUN || mode == M_STEP);
      if (clr_cnt) begin
        cyc = 0; ret = 0;
      end else begin
        if (en) cyc++;
        if (en && retire) ret++;
      end
      hit = 0;
`ifdef RUN_CTRL_WDOG_EN
      if (en && !retire && !clr_cnt) begin
        wd++;
        if (wd == WDOG) hit = 1;
      end else wd = 0;
`endif
      exp_done = 0;
      if (hit) begin
        mode = M_TO; exp_to = 1;
      end else if (mode == M_IDLE) begin
        if (step_req) begin
          mode = M_STEP; left = (step_n == 0) ? 1 : int'(step_n);
        end else if (run_req) mode = M_RUN;
      end else if (mode == M_RUN) begin
        if (halt_req) begin mode = M_IDLE; exp_done = 1; end
      end else if (mode == M_STEP) begin
        if (halt_req || left == 1) begin mode = M_IDLE; exp_done = 1; end
        else left--;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_halt();
    test_priority_clear();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
